// File: rtl/syncbus_fifo_dev_if.sv
// syncbus_fifo_dev_if: shared 16-bit bus segment plus consumer stream port
// for the transmit FIFO device.
// - The master side drives the data lines through master_oe/master_wdata.
// - The device side drives them through slave_oe/slave_rdata.
// - Both drivers are resolved here, so the lines float (Z) whenever neither
//   side is driving.
interface syncbus_fifo_dev_if;
  logic        req;
  logic        w;
  logic [15:0] address;
  wire  [15:0] data;
  logic        master_oe;
  logic [15:0] master_wdata;
  logic        slave_oe;
  logic [15:0] slave_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  // Resolve the shared data lines: the device wins during a decoded read, the master during its own cycles
  assign data = slave_oe ? slave_rdata : (master_oe ? master_wdata : 16'hzzzz);

  modport master (
    output req, w, address, master_oe, master_wdata, out_ready,
    input  data, slave_oe, out_valid, out_data
  );

  modport slave (
    input  req, w, address, data, out_ready,
    output slave_oe, slave_rdata, out_valid, out_data
  );
endinterface

// File: rtl/syncbus_fifo_dev.sv
// syncbus_fifo_dev: memory-mapped transmit FIFO on the 16-bit synchronous bus.
//
// Register window (three words starting at BASE):
//   BASE+0  DATA     write pushes a word; read returns 0
//   BASE+1  STATUS   read-only: {count[7:0], 5'b0, ovf, full, empty}
//   BASE+2  CONTROL  writing bit0 = 1 flushes the FIFO; read returns 0
//
// The consumer drains the FIFO through the out_valid/out_ready stream port.
// Define SYNCBUS_FIFO_OVF_EN to add a sticky overflow flag. Without it,
// dropped pushes are silent and STATUS bit 2 always reads 0.
module syncbus_fifo_dev #(
  parameter logic [15:0] BASE  = 16'hFFF8,
  parameter int          DEPTH = 8,
  parameter int          AW    = 3
) (
  input  logic              clock,
  input  logic              reset,
  syncbus_fifo_dev_if.slave bus
);

  localparam logic [15:0]   ADDR_DATA = BASE;
  localparam logic [15:0]   ADDR_STAT = BASE + 16'd1;
  localparam logic [15:0]   ADDR_CTRL = BASE + 16'd2;
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [15:0]   mem_r [DEPTH];
  logic [AW-1:0] wp_r;
  logic [AW-1:0] rp_r;
  logic [AW:0]   count_r;

  logic        empty_s;
  logic        full_s;
  logic        sel_data_s;
  logic        sel_stat_s;
  logic        sel_ctrl_s;
  logic        bus_wr_s;
  logic        bus_rd_s;
  logic        push_s;
  logic        pop_s;
  logic        flush_s;
  logic        stat_rd_s;
  logic        ovf_s;
  logic [15:0] rdata_s;

  assign empty_s    = (count_r == '0);
  assign full_s     = (count_r == CNT_FULL);
  assign sel_data_s = (bus.address == ADDR_DATA);
  assign sel_stat_s = (bus.address == ADDR_STAT);
  assign sel_ctrl_s = (bus.address == ADDR_CTRL);
  assign bus_wr_s   = bus.req & bus.w;
  assign bus_rd_s   = bus.req & ~bus.w;

  // A push into a full FIFO is dropped, even if a pop happens in the same cycle.
  assign push_s    = bus_wr_s & sel_data_s & ~full_s;
  assign pop_s     = ~empty_s & bus.out_ready;
  assign flush_s   = bus_wr_s & sel_ctrl_s & bus.data[0];
  assign stat_rd_s = bus_rd_s & sel_stat_s;

`ifdef SYNCBUS_FIFO_OVF_EN
  logic ovf_r;
  logic drop_s;

  assign drop_s = bus_wr_s & sel_data_s & full_s;

  // Sticky overflow flag: a drop wins over the clear from a same-cycle STATUS read.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ovf_r <= 1'b0;
    end else if (flush_s) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (stat_rd_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf_s = ovf_r;
`else
  assign ovf_s = 1'b0;
`endif

  // Pointer and occupancy update: reset, then flush, override any same-cycle push or pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp_r    <= '0;
      rp_r    <= '0;
      count_r <= '0;
    end else if (flush_s) begin
      wp_r    <= '0;
      rp_r    <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        wp_r <= wp_r + PTR_ONE;
      end else begin
        wp_r <= wp_r;
      end

      if (pop_s) begin
        rp_r <= rp_r + PTR_ONE;
      end else begin
        rp_r <= rp_r;
      end

      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write. The array is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (reset && !flush_s && push_s) begin
      mem_r[wp_r] <= bus.data;
    end
  end

  // Read mux for the register window: only STATUS returns a non-zero value.
  always_comb begin
    rdata_s = 16'h0000;
    if (sel_stat_s) begin
      rdata_s = {8'(count_r), 5'b00000, ovf_s, full_s, empty_s};
    end else begin
      rdata_s = 16'h0000;
    end
  end

  assign bus.slave_rdata = rdata_s;
  assign bus.slave_oe    = bus_rd_s & (sel_data_s | sel_stat_s | sel_ctrl_s);
  assign bus.out_valid   = ~empty_s;
  assign bus.out_data    = mem_r[rp_r];

endmodule
